// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART boot-load receive controller.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 15;
  localparam int DEF_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO, first-word-fall-through, with a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push when full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_boot_rx_ctrl.sv
// UART receive sequencer: boot-loads an instruction image, then buffers runtime bytes.
// state  | meaning
// S_LEN  | collecting the 4-byte little-endian word count
// S_DATA | collecting image words and writing them to instruction memory
// S_RUN  | load complete, good bytes go to the receive FIFO (terminal)
// S_ERR  | load aborted, receiver ignored (terminal)
module uart_boot_rx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              boot_done,
  output logic              load_err,
  input  logic              fifo_rd,
  output logic              fifo_empty,
  output logic [7:0]        fifo_dout,
  output logic              fifo_ovf,
  output logic              ferr_seen
);

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] remaining;
  logic [31:0] next_word;
  logic        last_byte;
  logic        good_byte;

  assign next_word = {rx_data, shift};
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign good_byte = rx_valid && !rx_ferr;
  assign boot_done = (state == S_RUN);
  assign load_err  = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_LEN;
      byte_cnt  <= 2'd0;
      shift     <= 24'd0;
      remaining <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      ferr_seen <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      case (state)
        S_LEN: begin
          if (rx_valid && rx_ferr) begin
            state <= S_ERR;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {rx_data, shift[23:8]};
            if (last_byte) begin
              if (next_word == 32'd0) begin
                state <= S_RUN;
              end else if ({1'b0, next_word} > MAX_WORDS) begin
                state <= S_ERR;
              end else begin
                state     <= S_DATA;
                remaining <= next_word;
              end
            end
          end
        end
        S_DATA: begin
          // remaining hits 0 during the final write pulse; finish one cycle later
          if (remaining == 32'd0) begin
            state <= S_RUN;
          end else if (rx_valid && rx_ferr) begin
            state <= S_ERR;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {rx_data, shift[23:8]};
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_wdata <= next_word;
              remaining <= remaining - 32'd1;
            end
          end
        end
        S_RUN: begin
          if (rx_valid && rx_ferr) ferr_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (good_byte && (state == S_RUN)),
    .din   (rx_data),
    .pop   (fifo_rd && (state == S_RUN)),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

endmodule

// File: tb/tb_uart_boot_rx_ctrl.sv
// Randomized bench for uart_boot_rx_ctrl with a byte-count based reference model.
module tb_uart_boot_rx_ctrl;

  localparam int ADDR_W = 15;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ferr = 1'b0;
  logic              fifo_rd = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              boot_done;
  logic              load_err;
  logic              fifo_empty;
  logic [7:0]        fifo_dout;
  logic              fifo_ovf;
  logic              ferr_seen;

  always #5 clk = ~clk;

  uart_boot_rx_ctrl #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .boot_done  (boot_done),
    .load_err   (load_err),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ovf   (fifo_ovf),
    .ferr_seen  (ferr_seen)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: load progress expressed as a count of accepted bytes.
  bit          e_we = 0, e_done = 0, e_err = 0, e_pend = 0, e_ovf = 0, e_ferr = 0;
  bit          we_prev, do_pop;
  logic [31:0] e_addr = 0, e_wdata = 0;
  longint      e_len = 0;
  int          n_ld;
  logic [7:0]  ld_bytes[$];
  logic [7:0]  e_q[$];

  function automatic logic [31:0] word_at(input int i);
    return {ld_bytes[i+3], ld_bytes[i+2], ld_bytes[i+1], ld_bytes[i]};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      e_we = 0; e_done = 0; e_err = 0; e_pend = 0; e_ovf = 0; e_ferr = 0;
      e_addr = 0; e_wdata = 0; e_len = 0;
      ld_bytes.delete();
      e_q.delete();
    end else begin
      we_prev = e_we;
      e_we = 0;
      if (we_prev) e_addr = (e_addr + 1) % (32'd1 << ADDR_W);
      if (e_err) begin
      end else if (e_done) begin
        if (rx_valid && rx_ferr) e_ferr = 1;
        do_pop = fifo_rd && (e_q.size() > 0);
        if (do_pop) void'(e_q.pop_front());
        if (rx_valid && !rx_ferr) begin
          if (e_q.size() < DEPTH) e_q.push_back(rx_data);
          else e_ovf = 1;
        end
      end else if (e_pend) begin
        e_done = 1;
      end else if (rx_valid) begin
        if (rx_ferr) begin
          e_err = 1;
        end else begin
          ld_bytes.push_back(rx_data);
          n_ld = ld_bytes.size();
          if (n_ld == 4) begin
            e_len = longint'(word_at(0));
            if (e_len == 0) e_done = 1;
            else if (e_len > (longint'(1) << ADDR_W)) e_err = 1;
          end else if (n_ld > 4 && (n_ld % 4) == 0) begin
            e_we = 1;
            e_wdata = word_at(n_ld - 4);
            if ((n_ld - 4) / 4 == e_len) e_pend = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("boot_done", 32'(boot_done), 32'(e_done));
      chk("load_err", 32'(load_err), 32'(e_err));
      chk("fifo_empty", 32'(fifo_empty), 32'(e_q.size() == 0));
      chk("fifo_ovf", 32'(fifo_ovf), 32'(e_ovf));
      chk("ferr_seen", 32'(ferr_seen), 32'(e_ferr));
      if (e_q.size() > 0) chk("fifo_dout", 32'(fifo_dout), 32'(e_q[0]));
    end
  end

  // Event log used by the hand-computed checks.
  int          we_count = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  int          byte_cyc = 0;
  bit          done_prev = 0;
  logic [31:0] mem_img [int];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      last_we_cyc = cyc;
      mem_img[int'(mem_addr)] = mem_wdata;
    end
    if (boot_done === 1'b1 && !done_prev) done_cyc = cyc;
    done_prev = (boot_done === 1'b1);
  end

  function automatic logic [31:0] img(input int a);
    return mem_img.exists(a) ? mem_img[a] : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    we_count = 0; last_we_cyc = -1; done_cyc = -1;
    mem_img.delete();
  endtask

  task automatic do_reset();
    rstn = 0; rx_valid = 0; rx_ferr = 0; fifo_rd = 0;
    tick(); tick();
    rstn = 1;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ferr, input int gap);
    rx_data = b; rx_valid = 1; rx_ferr = ferr; byte_cyc = cyc;
    tick();
    rx_valid = 0; rx_ferr = 0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, $urandom_range(gapmax, 0));
  endtask

  task automatic pop_one();
    fifo_rd = 1; tick(); fifo_rd = 0;
  endtask

  logic [7:0]  arr [17];
  logic [31:0] w;
  int          len;

  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst_boot_done", 32'(boot_done), 32'd0);

    // len=3 image
    send_word(32'd3, 2);
    send_word(32'h1122_3344, 2);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0000_0001, 1);
    repeat (3) tick();
    chk("t1_we_count", we_count, 3);
    chk("t1_addr0", img(0), 32'h1122_3344);
    chk("t1_addr1", img(1), 32'hDEAD_BEEF);
    chk("t1_addr2", img(2), 32'h0000_0001);
    chk("t1_done_lat", done_cyc, last_we_cyc + 1);

    // len=0, then first runtime byte
    do_reset();
    send_word(32'd0, 0);
    repeat (2) tick();
    chk("t2_we_count", we_count, 0);
    chk("t2_done_lat", done_cyc, byte_cyc + 1);
    send_byte(8'h5A, 1'b0, 0);
    chk("t2_dout", 32'(fifo_dout), 32'h5A);
    chk("t2_empty", 32'(fifo_empty), 32'd0);
    pop_one();
    chk("t2_empty_after_pop", 32'(fifo_empty), 32'd1);

    // frame error on 6th byte
    do_reset();
    send_word(32'd2, 0);
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h02, 1'b1, 0);
    chk("t3_load_err", 32'(load_err), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b0, 0);
    chk("t3_we_count", we_count, 0);
    chk("t3_boot_done", 32'(boot_done), 32'd0);
    do_reset();
    send_word(32'd1, 1);
    send_word(32'hA5A5_0F0F, 1);
    repeat (3) tick();
    chk("t3_reload_done", 32'(boot_done), 32'd1);
    chk("t3_reload_img", img(0), 32'hA5A5_0F0F);

    // length bounds
    do_reset();
    send_word(32'h0000_8001, 0);
    chk("t4_too_long", 32'(load_err), 32'd1);
    do_reset();
    send_word(32'h0000_8000, 0);
    chk("t4_max_ok_err", 32'(load_err), 32'd0);
    send_word(32'h0BAD_F00D, 0);
    tick();
    chk("t4_max_ok_we", we_count, 1);

    // overflow with 17 pushes, no pops
    do_reset();
    send_word(32'd0, 0);
    for (int i = 0; i < 17; i++) begin
      arr[i] = 8'($urandom);
      send_byte(arr[i], 1'b0, 0);
    end
    chk("t5_ovf", 32'(fifo_ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t5_readback", 32'(fifo_dout), 32'(arr[i]));
      pop_one();
    end
    chk("t5_drained", 32'(fifo_empty), 32'd1);
    pop_one();
    chk("t5_pop_empty", 32'(fifo_empty), 32'd1);

    // push while full with simultaneous pop
    do_reset();
    send_word(32'd0, 0);
    for (int i = 0; i < 16; i++) begin
      arr[i] = 8'($urandom);
      send_byte(arr[i], 1'b0, 0);
    end
    rx_data = 8'h77; rx_valid = 1; fifo_rd = 1;
    tick();
    rx_valid = 0; fifo_rd = 0;
    chk("t5_full_pushpop_ovf", 32'(fifo_ovf), 32'd0);
    chk("t5_full_pushpop_head", 32'(fifo_dout), 32'(arr[1]));
    repeat (15) pop_one();
    chk("t5_full_pushpop_tail", 32'(fifo_dout), 32'h77);

    // runtime frame error
    do_reset();
    send_word(32'd0, 0);
    send_byte(8'h33, 1'b1, 0);
    chk("t6_ferr_empty", 32'(fifo_empty), 32'd1);
    chk("t6_ferr_seen", 32'(ferr_seen), 32'd1);
    send_byte(8'h44, 1'b0, 0);
    chk("t6_next_byte", 32'(fifo_dout), 32'h44);

    // reset mid-word during S_DATA
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1234_5678, 0);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    rstn = 0;
    tick();
    chk("t7_rst_we", 32'(mem_we), 32'd0);
    chk("t7_rst_addr", 32'(mem_addr), 32'd0);
    chk("t7_rst_wdata", mem_wdata, 32'd0);
    chk("t7_rst_done", 32'(boot_done), 32'd0);
    chk("t7_rst_err", 32'(load_err), 32'd0);
    chk("t7_rst_empty", 32'(fifo_empty), 32'd1);
    rstn = 1;
    clear_log();
    send_word(32'd1, 1);
    send_word(32'hCAFE_F00D, 1);
    repeat (3) tick();
    chk("t7_relen_img", img(0), 32'hCAFE_F00D);
    chk("t7_relen_done", 32'(boot_done), 32'd1);

    // randomized loads and runtime traffic, checked by the model every cycle
    for (int it = 0; it < 20; it++) begin
      do_reset();
      len = $urandom_range(5, 0);
      send_word(32'(len), 2);
      for (int k = 0; k < len * 4; k++)
        send_byte(8'($urandom), ($urandom_range(59, 0) == 0), $urandom_range(2, 0));
      for (int c = 0; c < 60; c++) begin
        rx_data  = 8'($urandom);
        rx_valid = ($urandom_range(1, 0) == 1);
        rx_ferr  = rx_valid && ($urandom_range(9, 0) == 0);
        fifo_rd  = ($urandom_range(9, 0) < 4);
        tick();
      end
      rx_valid = 0; rx_ferr = 0; fifo_rd = 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
